// File: rtl/register_file_sb.sv
// register_file_sb: NREGS x WIDTH GPR file (2 async reads, 1 sync write, r0 = 0) with a per-register busy scoreboard.
//   Ports: CLK, nRST (async, active-low); rsel1/rsel2 -> rdat1/rdat2, busy1/busy2;
//          WEN/wsel/wdat write port (write also clears busy[wsel]); iss_en/iss_sel mark busy;
//          flush clears all busy bits; pend_cnt = number of busy registers.
//   Optional macro RF_BYPASS_EN: same-cycle write-through of wdat onto matching read ports.
module register_file_sb #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32,
    localparam int SELW = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [SELW-1:0]  rsel1,
    input  logic [SELW-1:0]  rsel2,
    output logic [WIDTH-1:0] rdat1,
    output logic [WIDTH-1:0] rdat2,
    input  logic             WEN,
    input  logic [SELW-1:0]  wsel,
    input  logic [WIDTH-1:0] wdat,
    input  logic             iss_en,
    input  logic [SELW-1:0]  iss_sel,
    input  logic             flush,
    output logic             busy1,
    output logic             busy2,
    output logic [SELW:0]    pend_cnt
);
    logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [NREGS-1:0]            busy_q, busy_d;
    logic [SELW:0]               pend_q, pend_d;

    // Clear before set so a same-cycle issue to the written register wins; flush overrides both.
    always_comb begin
        regs_d = regs_q;
        if (WEN && wsel != '0) regs_d[wsel] = wdat;
        busy_d = busy_q;
        if (WEN) busy_d[wsel] = 1'b0;
        if (iss_en && iss_sel != '0) busy_d[iss_sel] = 1'b1;
        if (flush) busy_d = '0;
        busy_d[0] = 1'b0;
        pend_d = '0;
        for (int i = 0; i < NREGS; i++) pend_d = pend_d + (SELW+1)'(busy_d[i]);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regs_q <= '0;
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    assign pend_cnt = pend_q;

`ifdef RF_BYPASS_EN
    logic byp1, byp2;
    assign byp1  = WEN && wsel == rsel1 && rsel1 != '0;
    assign byp2  = WEN && wsel == rsel2 && rsel2 != '0;
    assign rdat1 = byp1 ? wdat : regs_q[rsel1];
    assign rdat2 = byp2 ? wdat : regs_q[rsel2];
    // A forwarded value is no longer pending unless a newer producer issues to it now.
    assign busy1 = byp1 ? (iss_en && iss_sel == rsel1) : busy_q[rsel1];
    assign busy2 = byp2 ? (iss_en && iss_sel == rsel2) : busy_q[rsel2];
`else
    assign rdat1 = regs_q[rsel1];
    assign rdat2 = regs_q[rsel2];
    assign busy1 = busy_q[rsel1];
    assign busy2 = busy_q[rsel2];
`endif
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: scoreboard bench for register_file_sb (expectations queued, separate monitor compares).
module tb_register_file_sb;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [4:0]  rsel1, rsel2, wsel, iss_sel;
    logic [31:0] rdat1, rdat2, wdat;
    logic        WEN, iss_en, flush, busy1, busy2;
    logic [5:0]  pend_cnt;

    register_file_sb dut (
        .CLK(CLK), .nRST(nRST), .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2),
        .WEN(WEN), .wsel(wsel), .wdat(wdat), .iss_en(iss_en), .iss_sel(iss_sel), .flush(flush),
        .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
    );

    always #5 CLK = ~CLK;

    localparam int RD1 = 0, RD2 = 1, BS1 = 2, BS2 = 3, PND = 4;

    typedef struct {
        int          k;
        logic [31:0] v;
        string       nm;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   vectors = 0;
    int   errors = 0;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    initial begin
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = q.pop_front();
                act = e.k == RD1 ? rdat1 :
                      e.k == RD2 ? rdat2 :
                      e.k == BS1 ? {31'd0, busy1} :
                      e.k == BS2 ? {31'd0, busy2} : {26'd0, pend_cnt};
                vectors++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
                end
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_(input int k, input logic [31:0] v, input string nm);
        q.push_back('{k, v, nm});
    endtask

    task automatic fire;
        #1;
        ->chk_ev;
        #1;
    endtask

    task automatic idle;
        WEN = 0; iss_en = 0; flush = 0; wsel = 0; iss_sel = 0; wdat = 0;
    endtask

    initial begin
        nRST = 0; rsel1 = 5; rsel2 = 0;
        idle();
        #1;
        expect_(RD1, 0, "reset rdat1"); expect_(BS1, 0, "reset busy1"); expect_(PND, 0, "reset pend");
        fire();
        #5 nRST = 1;

        // reset mid-run
        tick(); WEN = 1; wsel = 5; wdat = 32'hDEADBEEF; iss_en = 1; iss_sel = 5;
        tick(); idle(); rsel1 = 5;
        expect_(RD1, 32'hDEADBEEF, "r5 write"); expect_(BS1, 1, "r5 busy"); expect_(PND, 1, "pend r5");
        fire();
        nRST = 0;
        expect_(RD1, 0, "async rst rdat1"); expect_(BS1, 0, "async rst busy1"); expect_(PND, 0, "async rst pend");
        fire();
        nRST = 1;

        // register 0
        tick(); WEN = 1; wsel = 0; wdat = 32'hFFFFFFFF; iss_en = 1; iss_sel = 0;
        tick(); idle(); rsel1 = 0; rsel2 = 0;
        expect_(RD1, 0, "r0 rdat1"); expect_(RD2, 0, "r0 rdat2"); expect_(BS1, 0, "r0 busy"); expect_(PND, 0, "r0 pend");
        fire();

        // scoreboard: issue 3, 7, 3 then write 7
        tick(); iss_en = 1; iss_sel = 3;
        tick(); iss_sel = 7; expect_(PND, 1, "pend after 3"); fire();
        tick(); iss_sel = 3; expect_(PND, 2, "pend after 7"); fire();
        tick(); iss_en = 0; expect_(PND, 2, "pend reissue 3"); fire();
        WEN = 1; wsel = 7; wdat = 32'h77;
        tick(); idle(); rsel1 = 7; rsel2 = 3;
        expect_(PND, 1, "pend wb 7"); expect_(BS1, 0, "busy7 cleared"); expect_(BS2, 1, "busy3 kept"); expect_(RD1, 32'h77, "r7 data");
        fire();

        // simultaneous set/clear on reg 9
        tick(); iss_en = 1; iss_sel = 9;
        tick(); idle(); rsel1 = 9;
        expect_(BS1, 1, "busy9 set"); expect_(PND, 2, "pend 3+9"); fire();
        iss_en = 1; iss_sel = 9; WEN = 1; wsel = 9; wdat = 32'h12;
        tick(); idle(); rsel1 = 9;
        expect_(BS1, 1, "set wins r9"); expect_(PND, 2, "pend same-reg"); expect_(RD1, 32'h12, "r9 data"); fire();

        // flush with 4 busy, concurrent issue and write
        tick(); iss_en = 1; iss_sel = 11;
        tick(); iss_sel = 13;
        tick(); idle(); expect_(PND, 4, "pend four"); fire();
        flush = 1; iss_en = 1; iss_sel = 2; WEN = 1; wsel = 6; wdat = 32'h66;
        tick(); idle(); rsel1 = 2; rsel2 = 3;
        expect_(PND, 0, "flush pend"); expect_(BS1, 0, "flush busy2"); expect_(BS2, 0, "flush busy3"); fire();
        rsel1 = 6; rsel2 = 13;
        expect_(RD1, 32'h66, "write during flush"); expect_(BS2, 0, "flush busy13"); fire();

        // bypass on port 2 with reg 4 busy
        tick(); iss_en = 1; iss_sel = 4;
        tick(); idle(); rsel2 = 4;
        expect_(BS2, 1, "busy4 set"); fire();
        WEN = 1; wsel = 4; wdat = 32'hA5;
        expect_(RD2, BYP ? 32'hA5 : 32'h0, "bypass rdat2"); expect_(BS2, BYP ? 0 : 1, "bypass busy2"); fire();
        tick(); idle(); rsel2 = 4;
        expect_(RD2, 32'hA5, "r4 next cycle"); expect_(BS2, 0, "busy4 cleared"); expect_(PND, 0, "pend after wb4"); fire();

        // top register
        WEN = 1; wsel = 31; wdat = 32'h31313131;
        tick(); idle(); rsel2 = 31; rsel1 = 5;
        expect_(RD2, 32'h31313131, "r31 data"); expect_(RD1, 0, "r5 after reset"); fire();

        #2;
        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL drain: got %0d unchecked expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
